vedic_mul_seq: RTL and testbench

Byte-serial sequencer around the combinational vedic16 16x16 multiplier, sized for the 8-bit TinyTapeout IO budget. It accepts four operand bytes over a valid/ready input stream and drives a and b of an internal vedic16 instance. It waits a programmable settle time, captures the 32-bit product, then streams it out as four bytes over a valid/ready output stream.

---
 rtl/vedic_mul_pkg.sv | 22 ++
 rtl/vedic16.sv | 74 +++++++
 rtl/vedic_mul_seq.sv | 158 +++++++++++++++
 tb/tb_vedic_mul_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_mul_pkg.sv
// Shared types and sizes for the byte-serial vedic multiplier sequencer.
package vedic_mul_pkg;

    // Operand, product and stream geometry
    localparam int unsigned OP_W   = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned NBYTES = 4;

    // Sequencer states; code 2'b11 is unused and recovers to ST_LOAD
    typedef enum logic [1:0] {
        ST_LOAD   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_UNLOAD = 2'b10
    } state_t;

    // Index of the byte being loaded or unloaded
    typedef logic [1:0] byte_idx_t;

    // Index of the final byte of a four-byte burst
    localparam byte_idx_t LAST_BYTE = byte_idx_t'(NBYTES - 1);

endpackage

// File: rtl/vedic16.sv
// Combinational 16x16 unsigned multiplier built from the Vedic
// "vertically and crosswise" decomposition: each NxN product is formed
// from four N/2 x N/2 sub-products, bottoming out in a 2x2 gate-level cell.
module vedic16
    import vedic_mul_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] r
);

    // 2x2 cell: partial products combined with two half adders
    function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
        logic t_lh;
        logic t_hl;
        logic t_hh;
        logic c1;
        t_lh = x[0] & y[1];
        t_hl = x[1] & y[0];
        t_hh = x[1] & y[1];
        c1   = t_lh & t_hl;
        return {t_hh & c1, t_hh ^ c1, t_lh ^ t_hl, x[0] & y[0]};
    endfunction

    // 4x4 from four 2x2 cells; crosswise terms are shifted by half width
    function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] p_ll;
        logic [3:0] p_hl;
        logic [3:0] p_lh;
        logic [3:0] p_hh;
        p_ll = vedic2(x[1:0], y[1:0]);
        p_hl = vedic2(x[3:2], y[1:0]);
        p_lh = vedic2(x[1:0], y[3:2]);
        p_hh = vedic2(x[3:2], y[3:2]);
        return {4'b0, p_ll}
             + {2'b0, p_hl, 2'b0}
             + {2'b0, p_lh, 2'b0}
             + {p_hh, 4'b0};
    endfunction

    // 8x8 from four 4x4 blocks
    function automatic logic [15:0] vedic8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p_ll;
        logic [7:0] p_hl;
        logic [7:0] p_lh;
        logic [7:0] p_hh;
        p_ll = vedic4(x[3:0], y[3:0]);
        p_hl = vedic4(x[7:4], y[3:0]);
        p_lh = vedic4(x[3:0], y[7:4]);
        p_hh = vedic4(x[7:4], y[7:4]);
        return {8'b0, p_ll}
             + {4'b0, p_hl, 4'b0}
             + {4'b0, p_lh, 4'b0}
             + {p_hh, 8'b0};
    endfunction

    logic [15:0] w_p_ll;
    logic [15:0] w_p_hl;
    logic [15:0] w_p_lh;
    logic [15:0] w_p_hh;

    // Top level: four 8x8 blocks summed into the full 32-bit product
    always_comb begin
        w_p_ll = vedic8(a[7:0],  b[7:0]);
        w_p_hl = vedic8(a[15:8], b[7:0]);
        w_p_lh = vedic8(a[7:0],  b[15:8]);
        w_p_hh = vedic8(a[15:8], b[15:8]);
        r      = {16'b0, w_p_ll}
               + {8'b0, w_p_hl, 8'b0}
               + {8'b0, w_p_lh, 8'b0}
               + {w_p_hh, 16'b0};
    end

endmodule

// File: rtl/vedic_mul_seq.sv
// Byte-serial wrapper around vedic16: loads two 16-bit operands as four
// bytes (a low, a high, b low, b high), waits MUL_LAT cycles for the
// multiplier to settle, then streams the 32-bit product out LSB first.
// Load and unload never overlap, so a single byte counter serves both.
module vedic_mul_seq
    import vedic_mul_pkg::*;
#(
    // Cycles from the final operand accept to product capture, 1..15
    parameter int unsigned MUL_LAT = 1,
    // Stream byte width; only 8 is supported
    parameter int unsigned BYTE_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    // wait_cnt value on which the product is captured
    localparam logic [3:0] WAIT_LAST = 4'(MUL_LAT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    byte_idx_t         r_byte_cnt;
    logic [3:0]        r_wait_cnt;
    logic [OP_W-1:0]   r_a_q;
    logic [OP_W-1:0]   r_b_q;
    logic [PROD_W-1:0] r_prod_q;
    logic [PROD_W-1:0] w_prod;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_last_byte;
    logic              w_last_wait;
    logic [BYTE_W-1:0] w_out_byte;

    // Multiplier sees only the held operand registers, stable through capture
    vedic16 u_mul (
        .a (r_a_q),
        .b (r_b_q),
        .r (w_prod)
    );

    // Handshake and counter terminal conditions
    always_comb begin
        w_in_fire   = in_valid & w_in_ready;
        w_out_fire  = w_out_valid & out_ready;
        w_last_byte = (r_byte_cnt == LAST_BYTE);
        w_last_wait = (r_wait_cnt == WAIT_LAST);
    end

    // State register: rst and clear both return to ST_LOAD
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst || clear) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no branch leaves the signal unassigned and infers a latch.
        w_state_nxt = r_state;
        unique case (r_state)
            ST_LOAD: begin
                if (w_in_fire && w_last_byte) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_last_wait) begin
                    w_state_nxt = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (w_out_fire && w_last_byte) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        w_in_ready  = (r_state == ST_LOAD);
        w_out_valid = (r_state == ST_UNLOAD);
        unique case (r_byte_cnt)
            2'd0:    w_out_byte = r_prod_q[1*BYTE_W-1:0*BYTE_W];
            2'd1:    w_out_byte = r_prod_q[2*BYTE_W-1:1*BYTE_W];
            2'd2:    w_out_byte = r_prod_q[3*BYTE_W-1:2*BYTE_W];
            default: w_out_byte = r_prod_q[4*BYTE_W-1:3*BYTE_W];
        endcase
        in_ready  = w_in_ready;
        out_valid = w_out_valid;
        out_data  = w_out_valid ? w_out_byte : '0;
        busy      = (r_state != ST_LOAD) || (r_byte_cnt != '0);
    end

    // Datapath: operand assembly, settle counter, product capture, byte index.
    // clear drops the transaction but keeps the operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_wait_cnt <= '0;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_prod_q   <= '0;
        end else if (clear) begin
            r_byte_cnt <= '0;
            r_wait_cnt <= '0;
            r_prod_q   <= '0;
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    r_wait_cnt <= '0;
                    if (w_in_fire) begin
                        unique case (r_byte_cnt)
                            2'd0:    r_a_q[BYTE_W-1:0]        <= in_data;
                            2'd1:    r_a_q[2*BYTE_W-1:BYTE_W] <= in_data;
                            2'd2:    r_b_q[BYTE_W-1:0]        <= in_data;
                            default: r_b_q[2*BYTE_W-1:BYTE_W] <= in_data;
                        endcase
                        r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + 2'd1;
                    end
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                    if (w_last_wait) begin
                        r_prod_q <= w_prod;
                    end
                end
                ST_UNLOAD: begin
                    if (w_out_fire) begin
                        r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + 2'd1;
                    end
                end
                default: begin
                    r_byte_cnt <= '0;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mul_seq.sv
// Directed bench for vedic_mul_seq. Two instances share all inputs:
// u_dut1 (MUL_LAT=1) carries most scenarios, u_dut3 (MUL_LAT=3) is
// observed only for the settle-latency scenario after a common reset.
module tb_vedic_mul_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready1, out_valid1, busy1;
    logic [7:0] out_data1;
    logic       in_ready3, out_valid3, busy3;
    logic [7:0] out_data3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vedic_mul_seq #(.MUL_LAT(1), .BYTE_W(8)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .out_data  (out_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .busy      (busy1)
    );

    vedic_mul_seq #(.MUL_LAT(3), .BYTE_W(8)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .busy      (busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $error("FAIL %s: observed=timeout expected=handshake", tag);
    endtask

    // Advance one clock and settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte on u_dut1's input stream, then idle for gap cycles
    task automatic send_byte(input logic [7:0] d, input int gap);
        logic was_ready;
        bit   done;
        done     = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            was_ready = in_ready1;
            step();
            if (was_ready) done = 1'b1;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (!done) timeout("send_byte");
        repeat (gap) step();
    endtask

    // Wait for out_valid on the chosen instance, compare the byte, let it transfer
    task automatic recv_byte(input bit sel3, input logic [7:0] exp, input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            if (sel3 ? out_valid3 : out_valid1) begin
                check(tag, sel3 ? out_data3 : out_data1, exp);
                done = 1'b1;
            end
            step();
        end
        if (!done) timeout(tag);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  in_ready1,  1);
        check("rst_out_valid", out_valid1, 0);
        check("rst_out_data",  out_data1,  0);
        check("rst_busy",      busy1,      0);

        // Basic 5 x 10 = 0x32, back-to-back
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_byte(8'h0A, 0);
        send_byte(8'h00, 0);
        check("basic_wait_valid", out_valid1, 0);
        check("basic_wait_ready", in_ready1,  0);
        check("basic_wait_busy",  busy1,      1);
        check("basic_wait_data",  out_data1,  0);
        step();
        check("basic_lat1_valid", out_valid1, 1);
        recv_byte(1'b0, 8'h32, "basic_b0");
        recv_byte(1'b0, 8'h00, "basic_b1");
        recv_byte(1'b0, 8'h00, "basic_b2");
        recv_byte(1'b0, 8'h00, "basic_b3");
        check("basic_done_ready", in_ready1,  1);
        check("basic_done_valid", out_valid1, 0);
        check("basic_done_busy",  busy1,      0);

        // Max operands 0xFFFF x 0xFFFF = 0xFFFE0001
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        recv_byte(1'b0, 8'h01, "max_b0");
        recv_byte(1'b0, 8'h00, "max_b1");
        recv_byte(1'b0, 8'hFE, "max_b2");
        recv_byte(1'b0, 8'hFF, "max_b3");

        // 43210 x 12345 = 0x1FCB74FA with two idle cycles between bytes
        send_byte(8'hCA, 2);
        check("gap_busy_midload", busy1,     1);
        check("gap_ready_midload", in_ready1, 1);
        send_byte(8'hA8, 2);
        send_byte(8'h39, 2);
        send_byte(8'h30, 0);
        recv_byte(1'b0, 8'hFA, "gap_b0");
        recv_byte(1'b0, 8'h74, "gap_b1");
        recv_byte(1'b0, 8'hCB, "gap_b2");
        recv_byte(1'b0, 8'h1F, "gap_b3");

        // Backpressure: 255 x 255 = 0xFE01, consumer stalls 3 cycles on byte 0
        out_ready = 1'b0;
        send_byte(8'hFF, 0);
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h00, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            check("bp_stall_valid", out_valid1, 1);
            check("bp_stall_data",  out_data1,  8'h01);
            check("bp_stall_ready", in_ready1,  0);
            step();
        end
        out_ready = 1'b1;
        recv_byte(1'b0, 8'h01, "bp_b0");
        recv_byte(1'b0, 8'hFE, "bp_b1");
        check("bp_unload_ready", in_ready1, 0);
        recv_byte(1'b0, 8'h00, "bp_b2");
        recv_byte(1'b0, 8'h00, "bp_b3");
        check("bp_done_ready", in_ready1, 1);

        // Clear after two bytes, then 7 x 9 = 0x3F
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        check("clr_busy_before", busy1, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_busy_after",  busy1,     0);
        check("clr_ready_after", in_ready1, 1);
        send_byte(8'h07, 0);
        send_byte(8'h00, 0);
        send_byte(8'h09, 0);
        send_byte(8'h00, 0);
        recv_byte(1'b0, 8'h3F, "clr_b0");
        recv_byte(1'b0, 8'h00, "clr_b1");
        recv_byte(1'b0, 8'h00, "clr_b2");
        recv_byte(1'b0, 8'h00, "clr_b3");

        // Reset during unload, after the first product byte of 3 x 4
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        recv_byte(1'b0, 8'h0C, "rstu_b0");
        check("rstu_pre_valid", out_valid1, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstu_valid", out_valid1, 0);
        check("rstu_data",  out_data1,  0);
        check("rstu_ready", in_ready1,  1);
        check("rstu_busy",  busy1,      0);
        check("rstu3_ready", in_ready3, 1);
        check("rstu3_busy",  busy3,     0);

        // Latency on the MUL_LAT=3 instance: 0x1000 x 0x0010 = 0x00010000
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        check("lat3_c0_valid", out_valid3, 0);
        check("lat3_c0_busy",  busy3,      1);
        step();
        check("lat3_c1_valid", out_valid3, 0);
        step();
        check("lat3_c2_valid", out_valid3, 0);
        step();
        check("lat3_c3_valid", out_valid3, 1);
        recv_byte(1'b1, 8'h00, "lat3_b0");
        recv_byte(1'b1, 8'h00, "lat3_b1");
        recv_byte(1'b1, 8'h01, "lat3_b2");
        recv_byte(1'b1, 8'h00, "lat3_b3");
        check("lat3_done_ready", in_ready3, 1);
        check("lat3_done_busy",  busy3,     0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
